uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg_if.sv | 22 ++
 rtl/uart_tx_cfg.sv | 143 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Transmit request/status bundle for uart_tx_cfg.
// Handshake: a request (i_Tx_DV) is taken at a rising edge where o_Tx_Ready is high; requests seen while not ready are dropped, never queued.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, 5..9 data bits LSB first, optional parity, 1 or 2 stop bits.
// Every output is a register loaded from the next-state decode, so the line changes cleanly on bit boundaries.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  uart_tx_cfg_if.slave tx,
  output logic [2:0]   o_Dbg_State
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam int            IW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          ODD_PAR  = (PARITY == 2);

  state_t               state_q   = S_IDLE;
  logic [CW-1:0]        clk_cnt_q = '0;
  logic [IW-1:0]        bit_idx_q = '0;
  logic                 stop_cnt_q = 1'b0;
  logic [DATA_BITS-1:0] data_q    = '0;
  logic                 serial_q  = 1'b1;
  logic                 active_q  = 1'b0;
  logic                 ready_q   = 1'b1;
  logic                 done_q    = 1'b0;

  state_t               state_d;
  logic [CW-1:0]        clk_cnt_d;
  logic [IW-1:0]        bit_idx_d;
  logic                 stop_cnt_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 serial_d;
  logic                 done_d;
  logic                 bit_end;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    done_d     = 1'b0;
    bit_end    = (clk_cnt_q == CNT_LAST);

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        clk_cnt_d  = '0;
        bit_idx_d  = '0;
        stop_cnt_d = 1'b0;
        if (tx.i_Tx_DV) begin
          data_d  = tx.i_Tx_Byte;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          // With two stop bits the first boundary only arms the second bit.
          if (STOP_BITS == 2 && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = S_IDLE;
            done_d     = 1'b1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        clk_cnt_d  = '0;
        bit_idx_d  = '0;
        stop_cnt_d = 1'b0;
      end
    endcase

    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = data_d[bit_idx_d];
      S_PARITY: serial_d = (^data_d) ^ ODD_PAR;
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      serial_q   <= serial_d;
      active_q   <= (state_d != S_IDLE);
      ready_q    <= (state_d == S_IDLE);
      done_q     <= done_d;
    end
  end

  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Ready  = ready_q;
  assign tx.o_Tx_Done   = done_q;
  assign o_Dbg_State    = state_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five differently configured instances checked cycle by cycle
// against a frame model built from the framing rules (bit list expanded by bit time).
module tb_uart_tx_cfg;
  localparam int N = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst;
  logic [N-1:0] dv;
  logic [8:0]   tx_byte [N];
  logic [N-1:0] ser, act, rdy, dn;
  logic [14:0]  dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [N];

  // configuration table: instance k
  function automatic int cfg_cpb(input int k);
    case (k)
      3:       return 87;
      4:       return 2;
      default: return 4;
    endcase
  endfunction
  function automatic int cfg_db(input int k);
    case (k)
      1, 2:    return 7;
      4:       return 9;
      default: return 8;
    endcase
  endfunction
  function automatic int cfg_par(input int k);
    case (k)
      1, 4:    return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction
  function automatic int cfg_sb(input int k);
    return (k == 1 || k == 2) ? 2 : 1;
  endfunction

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if3 ();
  uart_tx_cfg_if #(.DATA_BITS(9)) if4 ();

  assign if0.i_Tx_DV = dv[0];  assign if0.i_Tx_Byte = tx_byte[0][7:0];
  assign if1.i_Tx_DV = dv[1];  assign if1.i_Tx_Byte = tx_byte[1][6:0];
  assign if2.i_Tx_DV = dv[2];  assign if2.i_Tx_Byte = tx_byte[2][6:0];
  assign if3.i_Tx_DV = dv[3];  assign if3.i_Tx_Byte = tx_byte[3][7:0];
  assign if4.i_Tx_DV = dv[4];  assign if4.i_Tx_Byte = tx_byte[4][8:0];

  assign ser = {if4.o_Tx_Serial, if3.o_Tx_Serial, if2.o_Tx_Serial, if1.o_Tx_Serial, if0.o_Tx_Serial};
  assign act = {if4.o_Tx_Active, if3.o_Tx_Active, if2.o_Tx_Active, if1.o_Tx_Active, if0.o_Tx_Active};
  assign rdy = {if4.o_Tx_Ready,  if3.o_Tx_Ready,  if2.o_Tx_Ready,  if1.o_Tx_Ready,  if0.o_Tx_Ready};
  assign dn  = {if4.o_Tx_Done,   if3.o_Tx_Done,   if2.o_Tx_Done,   if1.o_Tx_Done,   if0.o_Tx_Done};

  uart_tx_cfg #(.CLKS_PER_BIT(4),  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Reset(rst[0]), .tx(if0), .o_Dbg_State(dbg[2:0]));
  uart_tx_cfg #(.CLKS_PER_BIT(4),  .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
    .i_Clock(clk), .i_Reset(rst[1]), .tx(if1), .o_Dbg_State(dbg[5:3]));
  uart_tx_cfg #(.CLKS_PER_BIT(4),  .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u2 (
    .i_Clock(clk), .i_Reset(rst[2]), .tx(if2), .o_Dbg_State(dbg[8:6]));
  uart_tx_cfg #(.CLKS_PER_BIT(87), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u3 (
    .i_Clock(clk), .i_Reset(rst[3]), .tx(if3), .o_Dbg_State(dbg[11:9]));
  uart_tx_cfg #(.CLKS_PER_BIT(2),  .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u4 (
    .i_Clock(clk), .i_Reset(rst[4]), .tx(if4), .o_Dbg_State(dbg[14:12]));

  always @(negedge clk) begin
    for (int j = 0; j < N; j++) if (dn[j]) done_cnt[j]++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: request presented at a negedge, taken at the following posedge
  task automatic start_frame(input int k, input logic [8:0] data);
    @(negedge clk);
    check_eq($sformatf("u%0d ready before request", k), 32'(rdy[k]), 32'd1);
    dv[k]      = 1'b1;
    tx_byte[k] = data;
    @(posedge clk);
    #1;
    dv[k] = 1'b0;
  endtask

  // scoreboard: expected bit list, each bit held for one bit time, then the done cycle
  task automatic check_frame(input int k, input logic [8:0] data);
    logic exp_q[$];
    int   cpb, nb, par, sb, ones, len;
    cpb  = cfg_cpb(k);
    nb   = cfg_db(k);
    par  = cfg_par(k);
    sb   = cfg_sb(k);
    ones = 0;
    exp_q.push_back(1'b0);
    for (int b = 0; b < nb; b++) begin
      exp_q.push_back(data[b]);
      ones += int'(data[b]);
    end
    if (par != 0) exp_q.push_back(((ones % 2) == 1) ^ (par == 2));
    for (int s = 0; s < sb; s++) exp_q.push_back(1'b1);
    len = exp_q.size() * cpb;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check_eq($sformatf("u%0d serial cyc%0d", k, i + 1), 32'(ser[k]), 32'(exp_q[i / cpb]));
      check_eq($sformatf("u%0d act/rdy/done cyc%0d", k, i + 1),
               32'({act[k], rdy[k], dn[k]}), 32'b100);
    end
    @(negedge clk);
    check_eq($sformatf("u%0d done cycle ser/act/rdy/done", k),
             32'({ser[k], act[k], rdy[k], dn[k]}), 32'b1011);
  endtask

  task automatic idle_check(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq($sformatf("u%0d idle ser/act/rdy/done", k),
               32'({ser[k], act[k], rdy[k], dn[k]}), 32'b1010);
    end
  endtask

  task automatic check_dones(input int k, input int exp, input string tag);
    @(posedge clk);
    #1;
    check_eq(tag, 32'(done_cnt[k]), 32'(exp));
  endtask

  initial begin
    int base;
    logic [8:0] rb;
    dv  = '0;
    rst = '1;
    for (int k = 0; k < N; k++) tx_byte[k] = '0;

    // reset state, with a request raised under reset on every instance
    repeat (2) @(posedge clk);
    @(negedge clk);
    dv = '1;
    for (int k = 0; k < N; k++) tx_byte[k] = 9'h155;
    @(posedge clk);
    #1;
    dv = '0;
    @(negedge clk);
    for (int k = 0; k < N; k++)
      check_eq($sformatf("u%0d reset ser/act/rdy/done", k),
               32'({ser[k], act[k], rdy[k], dn[k]}), 32'b1010);
    @(posedge clk);
    #1;
    rst = '0;
    idle_check(0, 3);

    // 8N1 byte 0x35
    base = done_cnt[0];
    start_frame(0, 9'h035);
    check_frame(0, 9'h035);
    check_dones(0, base + 1, "u0 single done for 0x35");

    // 7E2 and 7O2 with 0x07
    start_frame(1, 9'h007);
    check_frame(1, 9'h007);
    start_frame(2, 9'h007);
    check_frame(2, 9'h007);

    // long bit time, all-zero payload
    start_frame(3, 9'h000);
    check_frame(3, 9'h000);

    // DV held high: second frame must start right after the done cycle
    base = done_cnt[0];
    @(negedge clk);
    check_eq("u0 ready before b2b", 32'(rdy[0]), 32'd1);
    dv[0]      = 1'b1;
    tx_byte[0] = 9'h0A5;
    @(posedge clk);
    #1;
    tx_byte[0] = 9'h03C;
    check_frame(0, 9'h0A5);
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    check_frame(0, 9'h03C);
    idle_check(0, 8);
    check_dones(0, base + 2, "u0 two dones back-to-back");

    // request during DATA is dropped
    base = done_cnt[0];
    start_frame(0, 9'h05A);
    fork
      check_frame(0, 9'h05A);
      begin
        repeat (10) @(posedge clk);
        #1;
        dv[0]      = 1'b1;
        tx_byte[0] = 9'h0FF;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
      end
    join
    idle_check(0, 8);
    check_dones(0, base + 1, "u0 one done with ignored request");

    // reset during data bit 3 aborts the frame
    base = done_cnt[0];
    start_frame(0, 9'h096);
    repeat (17) @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check_eq("u0 after abort ser/act/rdy/done", 32'({ser[0], act[0], rdy[0], dn[0]}), 32'b1010);
    idle_check(0, 40);
    check_dones(0, base, "u0 no done after abort");
    start_frame(0, 9'h096);
    check_frame(0, 9'h096);

    // randomized frames with random idle gaps
    for (int k = 0; k < N; k++) begin
      if (k == 3) continue;
      for (int f = 0; f < 6; f++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        rb = 9'($urandom_range(0, 511));
        start_frame(k, rb);
        check_frame(k, rb);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
